// File: rtl/id_ex_register_if.sv
// ID/EX pipeline register interface.
// Carries the decoded ID-stage fields, the WB write-back port used for operand
// bypass/refresh, the EX-stage stall/flush controls, and the registered EX view.
//   master : ID/WB/hazard side (drives *_ID, *_WB, Stall_EX, Flush_EX)
//   slave  : the ID/EX register (drives *_EX and BubbleCount)
interface id_ex_register_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  // Hazard control
  logic             Stall_EX;
  logic             Flush_EX;
  // ID stage payload
  logic             Valid_ID;
  logic [XLEN-1:0]  PC_ID;
  logic [XLEN-1:0]  Imm_ID;
  logic [XLEN-1:0]  RD1_ID;
  logic [XLEN-1:0]  RD2_ID;
  logic [XLEN-1:0]  RD1F_ID;
  logic [XLEN-1:0]  RD2F_ID;
  logic [4:0]       Rs1_ID;
  logic [4:0]       Rs2_ID;
  logic [4:0]       Rd_ID;
  logic             RegWrite_ID;
  logic             RegWriteF_ID;
  logic             MemWrite_ID;
  logic             ResultSrc_ID;
  logic [3:0]       ALUControl_ID;
  // WB write port
  logic             RegWrite_WB;
  logic             RegWriteF_WB;
  logic [4:0]       Rd_WB;
  logic [XLEN-1:0]  Result_WB;
  // EX stage view
  logic             Valid_EX;
  logic [XLEN-1:0]  PC_EX;
  logic [XLEN-1:0]  Imm_EX;
  logic [XLEN-1:0]  RD1_EX;
  logic [XLEN-1:0]  RD2_EX;
  logic [XLEN-1:0]  RD1F_EX;
  logic [XLEN-1:0]  RD2F_EX;
  logic [4:0]       Rs1_EX;
  logic [4:0]       Rs2_EX;
  logic [4:0]       Rd_EX;
  logic             RegWrite_EX;
  logic             RegWriteF_EX;
  logic             MemWrite_EX;
  logic             ResultSrc_EX;
  logic [3:0]       ALUControl_EX;
  logic [CNT_W-1:0] BubbleCount;

  modport master (
    output Stall_EX, Flush_EX,
    output Valid_ID, PC_ID, Imm_ID, RD1_ID, RD2_ID, RD1F_ID, RD2F_ID,
    output Rs1_ID, Rs2_ID, Rd_ID, RegWrite_ID, RegWriteF_ID, MemWrite_ID,
    output ResultSrc_ID, ALUControl_ID,
    output RegWrite_WB, RegWriteF_WB, Rd_WB, Result_WB,
    input  Valid_EX, PC_EX, Imm_EX, RD1_EX, RD2_EX, RD1F_EX, RD2F_EX,
    input  Rs1_EX, Rs2_EX, Rd_EX, RegWrite_EX, RegWriteF_EX, MemWrite_EX,
    input  ResultSrc_EX, ALUControl_EX, BubbleCount
  );

  modport slave (
    input  Stall_EX, Flush_EX,
    input  Valid_ID, PC_ID, Imm_ID, RD1_ID, RD2_ID, RD1F_ID, RD2F_ID,
    input  Rs1_ID, Rs2_ID, Rd_ID, RegWrite_ID, RegWriteF_ID, MemWrite_ID,
    input  ResultSrc_ID, ALUControl_ID,
    input  RegWrite_WB, RegWriteF_WB, Rd_WB, Result_WB,
    output Valid_EX, PC_EX, Imm_EX, RD1_EX, RD2_EX, RD1F_EX, RD2F_EX,
    output Rs1_EX, Rs2_EX, Rd_EX, RegWrite_EX, RegWriteF_EX, MemWrite_EX,
    output ResultSrc_EX, ALUControl_EX, BubbleCount
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register.
// Captures decoded ID fields into EX with one cycle latency, inserts bubbles on
// flush (counted by a saturating counter), holds on stall, and bypasses WB
// results into the integer/float operands both on load and while held, so EX
// never sees a value the register files have not yet written.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : id_ex_register_if.slave (ID inputs, WB port, stall/flush, EX outputs)
module id_ex_register #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  id_ex_register_if.slave bus
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 4;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  rd1f;
    logic [XLEN-1:0]  rd2f;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             reg_write_f;
    logic             mem_write;
    logic             result_src;
    logic [ALU_W-1:0] alu_control;
  } ex_fields_t;

  ex_fields_t       ex_q, ex_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Source addresses compared against WB: ID addresses on load, held EX
  // addresses on stall, so the same hit logic serves bypass and refresh.
  logic [REG_W-1:0] src1_c, src2_c;
  logic             int_hit1_c, int_hit2_c, flt_hit1_c, flt_hit2_c;

  always_comb begin
    src1_c = bus.Stall_EX ? ex_q.rs1 : bus.Rs1_ID;
    src2_c = bus.Stall_EX ? ex_q.rs2 : bus.Rs2_ID;
  end

  // x0 is hardwired in the integer file only; float f0 is a real register.
  always_comb begin
    int_hit1_c = bus.RegWrite_WB && (bus.Rd_WB != REG_W'(0)) && (bus.Rd_WB == src1_c);
    int_hit2_c = bus.RegWrite_WB && (bus.Rd_WB != REG_W'(0)) && (bus.Rd_WB == src2_c);
    flt_hit1_c = bus.RegWriteF_WB && (bus.Rd_WB == src1_c);
    flt_hit2_c = bus.RegWriteF_WB && (bus.Rd_WB == src2_c);
  end

  // Next-state: flush beats stall beats load.
  always_comb begin
    ex_d     = ex_q;
    bubble_d = bubble_q;
    if (bus.Flush_EX) begin
      ex_d     = '0;
      bubble_d = (&bubble_q) ? bubble_q : bubble_q + CNT_W'(1);
    end else if (bus.Stall_EX) begin
      if (int_hit1_c) ex_d.rd1  = bus.Result_WB;
      if (int_hit2_c) ex_d.rd2  = bus.Result_WB;
      if (flt_hit1_c) ex_d.rd1f = bus.Result_WB;
      if (flt_hit2_c) ex_d.rd2f = bus.Result_WB;
    end else begin
      ex_d.valid       = bus.Valid_ID;
      ex_d.pc          = bus.PC_ID;
      ex_d.imm         = bus.Imm_ID;
      ex_d.rd1         = int_hit1_c ? bus.Result_WB : bus.RD1_ID;
      ex_d.rd2         = int_hit2_c ? bus.Result_WB : bus.RD2_ID;
      ex_d.rd1f        = flt_hit1_c ? bus.Result_WB : bus.RD1F_ID;
      ex_d.rd2f        = flt_hit2_c ? bus.Result_WB : bus.RD2F_ID;
      ex_d.rs1         = bus.Rs1_ID;
      ex_d.rs2         = bus.Rs2_ID;
      ex_d.rd          = bus.Rd_ID;
      // An invalid slot must never commit architectural state.
      ex_d.reg_write   = bus.RegWrite_ID  & bus.Valid_ID;
      ex_d.reg_write_f = bus.RegWriteF_ID & bus.Valid_ID;
      ex_d.mem_write   = bus.MemWrite_ID  & bus.Valid_ID;
      ex_d.result_src  = bus.ResultSrc_ID;
      ex_d.alu_control = bus.ALUControl_ID;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      bubble_q <= '0;
    end else begin
      ex_q     <= ex_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.Valid_EX      = ex_q.valid;
  assign bus.PC_EX         = ex_q.pc;
  assign bus.Imm_EX        = ex_q.imm;
  assign bus.RD1_EX        = ex_q.rd1;
  assign bus.RD2_EX        = ex_q.rd2;
  assign bus.RD1F_EX       = ex_q.rd1f;
  assign bus.RD2F_EX       = ex_q.rd2f;
  assign bus.Rs1_EX        = ex_q.rs1;
  assign bus.Rs2_EX        = ex_q.rs2;
  assign bus.Rd_EX         = ex_q.rd;
  assign bus.RegWrite_EX   = ex_q.reg_write;
  assign bus.RegWriteF_EX  = ex_q.reg_write_f;
  assign bus.MemWrite_EX   = ex_q.mem_write;
  assign bus.ResultSrc_EX  = ex_q.result_src;
  assign bus.ALUControl_EX = ex_q.alu_control;
  assign bus.BubbleCount   = bubble_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed vectors push hand-computed EX snapshots
// into a scoreboard queue; a negedge monitor pops and compares one per cycle.
module tb_id_ex_register;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_ex_register_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  rd1f;
    logic [XLEN-1:0]  rd2f;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             rw;
    logic             rwf;
    logic             mw;
    logic             rs;
    logic [3:0]       alu;
    logic [CNT_W-1:0] bc;
  } ex_t;

  typedef struct {
    string name;
    ex_t   e;
  } item_t;

  item_t            sb[$];
  int               total = 0;
  int               bad   = 0;
  logic [CNT_W-1:0] exp_bc;
  item_t            mon_it;
  ex_t              mon_act;
  ex_t              e;
  ex_t              e_s;

  // Monitor: one scoreboard entry per falling edge, compared against live outputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_it        = sb.pop_front();
      mon_act.valid = bus.Valid_EX;
      mon_act.pc    = bus.PC_EX;
      mon_act.imm   = bus.Imm_EX;
      mon_act.rd1   = bus.RD1_EX;
      mon_act.rd2   = bus.RD2_EX;
      mon_act.rd1f  = bus.RD1F_EX;
      mon_act.rd2f  = bus.RD2F_EX;
      mon_act.rs1   = bus.Rs1_EX;
      mon_act.rs2   = bus.Rs2_EX;
      mon_act.rd    = bus.Rd_EX;
      mon_act.rw    = bus.RegWrite_EX;
      mon_act.rwf   = bus.RegWriteF_EX;
      mon_act.mw    = bus.MemWrite_EX;
      mon_act.rs    = bus.ResultSrc_EX;
      mon_act.alu   = bus.ALUControl_EX;
      mon_act.bc    = bus.BubbleCount;
      total++;
      if (mon_act !== mon_it.e) begin
        bad++;
        $display("FAIL %s: got %h want %h", mon_it.name, mon_act, mon_it.e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ex_t base_exp();
    ex_t r;
    r       = '0;
    r.valid = 1'b1;
    r.pc    = 32'h100;
    r.imm   = 32'h10;
    r.rd1   = 32'h11;
    r.rd2   = 32'h22;
    r.rd1f  = 32'h33;
    r.rd2f  = 32'h44;
    r.rs1   = 5'd1;
    r.rs2   = 5'd2;
    r.rd    = 5'd3;
    r.rw    = 1'b1;
    r.rs    = 1'b1;
    r.alu   = 4'h2;
    r.bc    = exp_bc;
    return r;
  endfunction

  task automatic set_base();
    bus.Stall_EX      = 1'b0;
    bus.Flush_EX      = 1'b0;
    bus.Valid_ID      = 1'b1;
    bus.PC_ID         = 32'h100;
    bus.Imm_ID        = 32'h10;
    bus.RD1_ID        = 32'h11;
    bus.RD2_ID        = 32'h22;
    bus.RD1F_ID       = 32'h33;
    bus.RD2F_ID       = 32'h44;
    bus.Rs1_ID        = 5'd1;
    bus.Rs2_ID        = 5'd2;
    bus.Rd_ID         = 5'd3;
    bus.RegWrite_ID   = 1'b1;
    bus.RegWriteF_ID  = 1'b0;
    bus.MemWrite_ID   = 1'b0;
    bus.ResultSrc_ID  = 1'b1;
    bus.ALUControl_ID = 4'h2;
    bus.RegWrite_WB   = 1'b0;
    bus.RegWriteF_WB  = 1'b0;
    bus.Rd_WB         = 5'd0;
    bus.Result_WB     = 32'h0;
  endtask

  task automatic push_now(input string name, input ex_t x);
    item_t it;
    it.name = name;
    it.e    = x;
    sb.push_back(it);
  endtask

  task automatic push_after_edge(input string name, input ex_t x);
    @(posedge clk);
    #1;
    push_now(name, x);
  endtask

  initial begin
    rst_n  = 1'b0;
    exp_bc = '0;
    set_base();
    #1;
    push_now("reset_state", '0);

    @(negedge clk);
    rst_n = 1'b1;
    push_after_edge("load_after_reset", base_exp());

    // Asynchronous reset while clk is low and contents are non-zero.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 push_now("mid_cycle_reset", '0);

    @(negedge clk);
    rst_n = 1'b1;
    set_base();
    push_after_edge("reload", base_exp());

    @(negedge clk);
    set_base();
    bus.Rs1_ID = 5'd5; bus.RegWrite_WB = 1'b1; bus.Rd_WB = 5'd5; bus.Result_WB = 32'hAA;
    e = base_exp(); e.rs1 = 5'd5; e.rd1 = 32'hAA;
    push_after_edge("int_bypass", e);

    @(negedge clk);
    set_base();
    bus.Rs1_ID = 5'd0; bus.RegWrite_WB = 1'b1; bus.Rd_WB = 5'd0; bus.Result_WB = 32'hAA;
    e = base_exp(); e.rs1 = 5'd0;
    push_after_edge("int_x0_no_bypass", e);

    @(negedge clk);
    set_base();
    bus.Rs2_ID = 5'd0; bus.RegWriteF_WB = 1'b1; bus.Rd_WB = 5'd0; bus.Result_WB = 32'h3F800000;
    e = base_exp(); e.rs2 = 5'd0; e.rd2f = 32'h3F800000;
    push_after_edge("float_f0_bypass", e);

    @(negedge clk);
    set_base();
    bus.RegWrite_WB = 1'b1; bus.RegWriteF_WB = 1'b1; bus.Rd_WB = 5'd2; bus.Result_WB = 32'h77;
    e = base_exp(); e.rd2 = 32'h77; e.rd2f = 32'h77;
    push_after_edge("int_and_float_bypass", e);

    @(negedge clk);
    set_base();
    bus.RegWrite_WB = 1'b1; bus.Rd_WB = 5'd1; bus.Result_WB = 32'h99;
    e = base_exp(); e.rd1 = 32'h99;
    push_after_edge("int_only_bypass", e);

    @(negedge clk);
    set_base();
    bus.Valid_ID = 1'b0; bus.RegWriteF_ID = 1'b1; bus.MemWrite_ID = 1'b1;
    e = base_exp(); e.valid = 1'b0; e.rw = 1'b0;
    push_after_edge("invalid_load", e);

    @(negedge clk);
    set_base();
    bus.Rs2_ID = 5'd7; bus.RD2_ID = 32'h1;
    e_s = base_exp(); e_s.rs2 = 5'd7; e_s.rd2 = 32'h1;
    push_after_edge("stall_setup", e_s);

    @(negedge clk);
    set_base();
    bus.Stall_EX = 1'b1; bus.PC_ID = 32'h999; bus.RD2_ID = 32'h123; bus.Rs2_ID = 5'd8;
    push_after_edge("stall_hold", e_s);

    @(negedge clk);
    set_base();
    bus.Stall_EX = 1'b1; bus.PC_ID = 32'h999; bus.RD2_ID = 32'h123; bus.Rs2_ID = 5'd8;
    bus.RegWrite_WB = 1'b1; bus.Rd_WB = 5'd7; bus.Result_WB = 32'h55;
    e_s.rd2 = 32'h55;
    push_after_edge("stall_int_refresh", e_s);

    @(negedge clk);
    set_base();
    bus.Stall_EX = 1'b1;
    bus.RegWriteF_WB = 1'b1; bus.Rd_WB = 5'd7; bus.Result_WB = 32'h66;
    e_s.rd2f = 32'h66;
    push_after_edge("stall_float_refresh", e_s);

    @(negedge clk);
    set_base();
    bus.Rd_ID = 5'd9;
    e = base_exp(); e.rd = 5'd9;
    push_after_edge("load_rd9", e);

    // Flush and stall together: flush wins, WB match must not refresh.
    @(negedge clk);
    set_base();
    bus.Stall_EX = 1'b1; bus.Flush_EX = 1'b1;
    bus.RegWrite_WB = 1'b1; bus.Rd_WB = 5'd1; bus.Result_WB = 32'hEE;
    exp_bc = 2'd1;
    e = '0; e.bc = exp_bc;
    push_after_edge("flush_over_stall", e);

    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      set_base();
      bus.Flush_EX = 1'b1;
      exp_bc = (i >= 3) ? 2'd3 : 2'd2;
      e = '0; e.bc = exp_bc;
      push_after_edge($sformatf("flush_%0d", i), e);
    end

    @(negedge clk);
    set_base();
    push_after_edge("load_after_saturation", base_exp());

    for (int k = 0; k < 5 && sb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d entries left, want 0", sb.size());
      bad = bad + sb.size();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- ID/EX pipeline register of the RV pipeline; captures decoded operands, register addresses and control from ID and presents them to EX.
- Drives Rs1_EX/Rs2_EX and operand values consumed by the EX forwarding muxes and forwarding logic.
- Closes the WB-to-ID gap: captures WB results that the register files have not yet written, including while EX is stalled, so EX operands are never stale.

Parameters:
- XLEN, 32, integer and float datapath width.
- CNT_W, 16, width of saturating bubble counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Stall_EX  in  1  hold current EX contents
- Flush_EX  in  1  load bubble
- Valid_ID  in  1  ID holds real instruction
- PC_ID  in  XLEN  instruction PC
- Imm_ID  in  XLEN  extended immediate
- RD1_ID, RD2_ID  in  XLEN  integer regfile reads
- RD1F_ID, RD2F_ID  in  XLEN  float regfile reads
- Rs1_ID, Rs2_ID, Rd_ID  in  5  register addresses
- RegWrite_ID, RegWriteF_ID, MemWrite_ID, ResultSrc_ID  in  1  control
- ALUControl_ID  in  4  ALU/FPU operation
- RegWrite_WB, RegWriteF_WB  in  1  WB write enables
- Rd_WB  in  5  WB destination
- Result_WB  in  XLEN  WB data
- Valid_EX  out  1  EX holds real instruction
- PC_EX, Imm_EX, RD1_EX, RD2_EX, RD1F_EX, RD2F_EX  out  XLEN  registered copies
- Rs1_EX, Rs2_EX, Rd_EX  out  5
- RegWrite_EX, RegWriteF_EX, MemWrite_EX, ResultSrc_EX  out  1
- ALUControl_EX  out  4
- BubbleCount  out  CNT_W  flush-inserted bubbles, saturating

Behaviour:
- Reset (rst_n low, async): every output 0; Valid_EX=0, BubbleCount=0. First capture on first rising edge after deassertion.
- Priority per edge: Flush_EX > Stall_EX > load.
- Load (no flush, no stall): all *_EX <= *_ID, one cycle latency; Valid_EX <= Valid_ID.
- Load with Valid_ID=0: captured as-is, but RegWrite_EX, RegWriteF_EX and MemWrite_EX are forced 0.
- Flush: Valid_EX, RegWrite_EX, RegWriteF_EX, MemWrite_EX, ResultSrc_EX <= 0; Rs1_EX, Rs2_EX, Rd_EX <= 0 so the forwarding logic sees no match; data fields don't-care (implement as 0).
- Flush counting: BubbleCount increments on each flush edge, saturates at all-ones.
- Stall: all fields hold, except the operand-refresh rules below.
- Integer WB bypass on load: if RegWrite_WB, Rd_WB!=0 and Rd_WB==Rs1_ID, RD1_EX <= Result_WB instead of RD1_ID. Same rule for Rs2_ID/RD2_EX.
- Float WB bypass on load: if RegWriteF_WB and Rd_WB==Rs1_ID, RD1F_EX <= Result_WB. Register 0 is not excluded for float. Same rule for Rs2_ID/RD2F_EX.
- Stall refresh: while Stall_EX, if the WB write matches Rs1_EX/Rs2_EX (same x0 rule per file), the corresponding held operand <= Result_WB. Other fields hold.
- Int/float independence: RegWrite_WB only updates integer operands; RegWriteF_WB only updates float operands. Both asserted with a match updates both.
- Simultaneous Flush_EX and Stall_EX: flush wins; no refresh.
- Reset mid-stall: clears immediately regardless of clk.
- Internal state: pipeline fields and BubbleCount only; no other storage.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with non-zero contents -> all outputs 0 immediately; after release, one load with PC_ID=0x100, Valid_ID=1 -> PC_EX=0x100, Valid_EX=1 next edge.
- Int WB bypass: Rs1_ID=5, RD1_ID=0x11, RegWrite_WB=1, Rd_WB=5, Result_WB=0xAA -> RD1_EX=0xAA. Repeat with Rd_WB=0, Rs1_ID=0 -> RD1_EX=0x11.
- Float bypass including x0: RegWriteF_WB=1, Rd_WB=0, Rs2_ID=0, Result_WB=0x3F800000 -> RD2F_EX=0x3F800000, RD2_EX unchanged by WB.
- Stall refresh: load Rs2_EX=7, RD2_EX=0x1; hold Stall_EX 2 cycles; in cycle 2, RegWrite_WB=1, Rd_WB=7, Result_WB=0x55 -> RD2_EX=0x55, all other fields unchanged.
- Flush vs stall: Stall_EX=Flush_EX=1 with RegWrite_EX=1, Rd_EX=9 -> Valid_EX=0, RegWrite_EX=0, Rd_EX=0, BubbleCount +1.
- Counter saturation: preload via 2^CNT_W-1 flushes (or CNT_W=2 build, 4 flushes) -> BubbleCount stays at 3.
